pc_fetch_unit: RTL
==================

Name: pc_fetch_unit

Overview:
Instruction-fetch stage upstream of the next-address logic. Holds the 30-bit word-addressed fetch PC and issues requests to instruction memory over a req/ack handshake with variable latency. Delivers instruction plus PC to decode through an IF/ID output register with a one-entry skid buffer. Accepts redirect targets (NextPC from next-address logic on taken branch/jump/register jump) and flushes wrong-path fetches.

Parameters:
RESET_PC, 30'h0000000, fetch PC (word address) loaded on reset
INSTR_W, 32, instruction width

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
next_pc  in  30  redirect target (word address) from next-address logic
redirect  in  1  take next_pc; flush in-flight/buffered wrong-path fetches
stall  in  1  decode cannot accept; IF/ID output must hold
imem_req  out  1  fetch request; held high until imem_ack
imem_addr  out  30  word address; stable while imem_req high
imem_ack  in  1  one-cycle pulse; imem_rdata valid in same cycle
imem_rdata  in  INSTR_W  fetched instruction
if_valid  out  1  IF/ID holds a valid instruction
if_instr  out  INSTR_W  IF/ID instruction
if_pc  out  30  PC of if_instr; drives next-address PC input
if_incr_pc  out  30  if_pc+1 modulo 2^30

Behaviour:
- Reset (rst=1 at edge): state=FETCH, fetch_pc=RESET_PC, if_valid=0, if_instr=0, if_pc=0, skid empty, redir_pc=0. imem_req=1 in first cycle after reset.
- Consume: downstream takes IF/ID when if_valid && !stall. Slot free = !if_valid || !stall.
- States: FETCH, HOLD, DRAIN. imem_req=1 in FETCH and DRAIN, 0 in HOLD. imem_addr=fetch_pc.
- FETCH, ack, no redirect, slot free: IF/ID <= {rdata, fetch_pc}, if_valid=1, fetch_pc+=1, remain FETCH (back-to-back; zero-wait memory gives 1 instr/cycle).
- FETCH, ack, no redirect, slot not free: rdata/fetch_pc into skid, fetch_pc+=1, go HOLD.
- HOLD: when !stall, skid -> IF/ID, skid empty, go FETCH.
- FETCH, no ack, slot not free: keep requesting (req must not drop mid-handshake).
- FETCH, no ack: if !stall and no load, if_valid<=0 after consumption.
- Redirect (priority over stall and ack data): if_valid<=0, skid cleared next edge.
  * FETCH with ack same cycle: data discarded, fetch_pc<=next_pc, stay FETCH.
  * FETCH without ack: redir_pc<=next_pc, go DRAIN (addr held).
  * DRAIN: req/addr held for old fetch; further redirect overwrites redir_pc (latest wins); on ack discard data, fetch_pc<=redir_pc, go FETCH.
  * HOLD: fetch_pc<=next_pc, go FETCH.
- Ack outside FETCH/DRAIN is ignored.
- Arithmetic: all PC increments modulo 2^30; 30'h3FFFFFFF+1 = 0.
- Reset mid-handshake: state forced to FETCH at RESET_PC; memory must drop the stale request on rst.

Optional Feature:
FETCH_FLUSH_CNT_EN: adds output fetch_flush_cnt[15:0], a saturating count (stops at 16'hFFFF) of discarded instructions (valid IF/ID or skid entry flushed, or ack data discarded in DRAIN/FETCH-redirect). Reset to 0. Without the macro the port and counter do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package: PC_W=30, INSTR_W default, fetch state enum {FETCH, HOLD, DRAIN}, RESET_PC default.
- Sub-module: fetch_skid_reg, a one-entry {instr, pc} buffer with load/unload/clear.

Test Plan:
- Reset, zero-wait memory (ack same cycle as req), stall=0 -> if_pc 0,1,2,3 on consecutive cycles, if_valid=1 from second cycle after reset.
- Hold stall=1 for 3 cycles with ack at fetch_pc=5 -> skid holds pc 5, HOLD (imem_req=0); after stall drops, if_pc=5 then fetch resumes at 6, with no loss or duplication.
- Redirect next_pc=30'h100 while req to 7 outstanding, ack 2 cycles later -> DRAIN, ack data dropped, next imem_addr=0x100, if_valid=0 until pc 0x100 arrives.
- Two redirects in DRAIN (0x200 then 0x300) -> first post-drain fetch at 0x300.
- RESET_PC=30'h3FFFFFFF -> if_pc 3FFFFFFF then 0; if_incr_pc=0 for first.
- FETCH_FLUSH_CNT_EN defined: redirect with IF/ID valid and skid full -> fetch_flush_cnt +2. Force 0xFFFF, flush again -> stays 0xFFFF.

Source files
------------

// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package pc_fetch_unit_pkg;

  localparam int              PC_W         = 30;
  localparam int              INSTR_W_DEF  = 32;
  localparam logic [PC_W-1:0] RESET_PC_DEF = 30'h0000000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  // Word-address increment; the 30-bit width makes it wrap 3FFFFFFF -> 0.
  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
    return pc + {{(PC_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory req/ack channel between the fetch stage and imem.
interface pc_fetch_unit_if #(
  parameter int INSTR_W = 32
);
  import pc_fetch_unit_pkg::*;

  logic               req;
  logic [PC_W-1:0]    addr;
  logic               ack;
  logic [INSTR_W-1:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);

endinterface

// File: rtl/pc_fetch_unit_skid.sv
// One-entry {instr, pc} skid buffer; clear and unload both empty it.
module fetch_skid_reg #(
  parameter int INSTR_W = 32,
  parameter int PC_W    = 30
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               unload_i,
  input  logic               clear_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [PC_W-1:0]    pc_i,
  output logic               vld_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [PC_W-1:0]    pc_o
);

  logic               vld_q;
  logic [INSTR_W-1:0] instr_q;
  logic [PC_W-1:0]    pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else if (clear_i || unload_i) begin
      vld_q   <= 1'b0;
    end else if (load_i) begin
      vld_q   <= 1'b1;
      instr_q <= instr_i;
      pc_q    <= pc_i;
    end
  end

  assign vld_o   = vld_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: PC, imem req/ack, IF/ID register with skid, redirect flush.
// Optional FETCH_FLUSH_CNT_EN adds a saturating discarded-instruction counter.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF,
  parameter int              INSTR_W  = INSTR_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PC_W-1:0]     next_pc_i,
  input  logic                redirect_i,
  input  logic                stall_i,
  pc_fetch_unit_if.master     imem,
  output logic                if_valid_o,
  output logic [INSTR_W-1:0]  if_instr_o,
  output logic [PC_W-1:0]     if_pc_o,
`ifdef FETCH_FLUSH_CNT_EN
  output logic [15:0]         fetch_flush_cnt_o,
`endif
  output logic [PC_W-1:0]     if_incr_pc_o
);

  fetch_state_e       state_q, state_d;
  logic               req_q, req_d;
  logic [PC_W-1:0]    fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]    redir_pc_q, redir_pc_d;
  logic               if_valid_q, if_valid_d;
  logic [INSTR_W-1:0] if_instr_q, if_instr_d;
  logic [PC_W-1:0]    if_pc_q, if_pc_d;

  logic               skid_load, skid_unload, skid_clear, skid_vld;
  logic [INSTR_W-1:0] skid_instr;
  logic [PC_W-1:0]    skid_pc;
  logic               slot_free;

  assign slot_free = !if_valid_q || !stall_i;

  fetch_skid_reg #(.INSTR_W(INSTR_W), .PC_W(PC_W)) u_skid (
    .clk      (clk),
    .rst      (rst),
    .load_i   (skid_load),
    .unload_i (skid_unload),
    .clear_i  (skid_clear),
    .instr_i  (imem.rdata),
    .pc_i     (fetch_pc_q),
    .vld_o    (skid_vld),
    .instr_o  (skid_instr),
    .pc_o     (skid_pc)
  );

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    redir_pc_d  = redir_pc_q;
    if_valid_d  = if_valid_q && stall_i;
    if_instr_d  = if_instr_q;
    if_pc_d     = if_pc_q;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    skid_clear  = 1'b0;
    unique case (state_q)
      FETCH: begin
        if (redirect_i) begin
          if_valid_d = 1'b0;
          skid_clear = 1'b1;
          if (imem.ack) fetch_pc_d = next_pc_i;
          else begin
            // Outstanding request cannot be withdrawn: wait it out in DRAIN.
            redir_pc_d = next_pc_i;
            state_d    = DRAIN;
          end
        end else if (imem.ack) begin
          fetch_pc_d = pc_inc(fetch_pc_q);
          if (slot_free) begin
            if_valid_d = 1'b1;
            if_instr_d = imem.rdata;
            if_pc_d    = fetch_pc_q;
          end else begin
            skid_load = 1'b1;
            state_d   = HOLD;
          end
        end
      end
      HOLD: begin
        if (redirect_i) begin
          if_valid_d = 1'b0;
          skid_clear = 1'b1;
          fetch_pc_d = next_pc_i;
          state_d    = FETCH;
        end else if (!stall_i) begin
          if_valid_d  = skid_vld;
          if_instr_d  = skid_instr;
          if_pc_d     = skid_pc;
          skid_unload = 1'b1;
          state_d     = FETCH;
        end
      end
      DRAIN: begin
        if (redirect_i) begin
          if_valid_d = 1'b0;
          skid_clear = 1'b1;
          redir_pc_d = next_pc_i;
        end
        if (imem.ack) begin
          fetch_pc_d = redirect_i ? next_pc_i : redir_pc_q;
          state_d    = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
    req_d = (state_d != HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH;
      req_q      <= 1'b1;
      fetch_pc_q <= RESET_PC;
      redir_pc_q <= '0;
      if_valid_q <= 1'b0;
      if_instr_q <= '0;
      if_pc_q    <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      fetch_pc_q <= fetch_pc_d;
      redir_pc_q <= redir_pc_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
    end
  end

`ifdef FETCH_FLUSH_CNT_EN
  logic [15:0] flush_cnt_q, flush_cnt_d;
  logic        drop;
  logic [1:0]  n_flush;
  logic [16:0] cnt_sum;

  // Ack data thrown away: redirect in FETCH with ack, or any ack in DRAIN.
  assign drop    = imem.ack && ((state_q == FETCH && redirect_i) || state_q == DRAIN);
  assign n_flush = {1'b0, drop}
                 + {1'b0, redirect_i && if_valid_q}
                 + {1'b0, redirect_i && skid_vld};
  assign cnt_sum = {1'b0, flush_cnt_q} + {15'd0, n_flush};
  assign flush_cnt_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];

  always_ff @(posedge clk) begin
    if (rst) flush_cnt_q <= '0;
    else     flush_cnt_q <= flush_cnt_d;
  end

  assign fetch_flush_cnt_o = flush_cnt_q;
`endif

  assign imem.req     = req_q;
  assign imem.addr    = fetch_pc_q;
  assign if_valid_o   = if_valid_q;
  assign if_instr_o   = if_instr_q;
  assign if_pc_o      = if_pc_q;
  assign if_incr_pc_o = pc_inc(if_pc_q);

endmodule
